// File: rtl/div_arbiter_pkg.sv
// Shared types and default widths for the divider arbiter slice.
package div_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int N_DEF       = 32;
  localparam int DIGIT_DEF   = 32;
  localparam int TIMEOUT_DEF = 127;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_DBZ     = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cand[i] = IDW'((int'(ptr) + i) % NREQ);
    end
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[cand[i]]) begin
        any = 1'b1;
        idx = cand[i];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front-end for one shared iterative divider, with local
// divide-by-zero trap and a WAIT watchdog.
//
//   state   | meaning
//   S_IDLE  | pick a requester, latch operands (DBZ goes straight to S_RESP)
//   S_ISSUE | one-cycle start pulse to the divider, clear watchdog
//   S_WAIT  | wait for done or watchdog expiry
//   S_RESP  | hold response until rsp_ready_i, then advance pointer
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int N       = N_DEF,
  parameter int DIGIT   = DIGIT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ-1:0][N-1:0]    req_dividend_i,
  input  logic [NREQ-1:0][N-1:0]    req_divisor_i,
  output logic                      div_start_o,
  output logic [N-1:0]              div_dividend_o,
  output logic [N-1:0]              div_divisor_o,
  input  logic                      div_done_i,
  input  logic [N+DIGIT-1:0]        div_quot_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [IDW-1:0]            rsp_id_o,
  output logic [N+DIGIT-1:0]        rsp_quot_o,
  output logic [1:0]                rsp_status_o
);

  localparam int QW  = N + DIGIT;
  localparam int WDW = $clog2(TIMEOUT + 1);
  // Count seen in the last allowed WAIT cycle; expiry here gives exactly TIMEOUT WAIT cycles.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [IDW-1:0]  gid, gid_n;
  logic [N-1:0]    opa, opa_n;
  logic [N-1:0]    opb, opb_n;
  logic [QW-1:0]   quot, quot_n;
  status_t         status, status_n;
  logic [WDW-1:0]  wdog, wdog_n;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready_o    = (state == S_IDLE) ? pick_gnt : '0;
  assign div_start_o    = (state == S_ISSUE);
  assign div_dividend_o = opa;
  assign div_divisor_o  = opb;
  assign rsp_valid_o    = (state == S_RESP);
  assign rsp_id_o       = gid;
  assign rsp_quot_o     = quot;
  assign rsp_status_o   = status;

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gid_n    = gid;
    opa_n    = opa;
    opb_n    = opb;
    quot_n   = quot;
    status_n = status;
    wdog_n   = wdog;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          gid_n = pick_idx;
          opa_n = req_dividend_i[pick_idx];
          opb_n = req_divisor_i[pick_idx];
          if (req_divisor_i[pick_idx] == '0) begin
            quot_n   = '1;
            status_n = ST_DBZ;
            state_n  = S_RESP;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wdog_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        wdog_n = wdog + WDW'(1);
        if (div_done_i) begin
          quot_n   = div_quot_i;
          status_n = ST_OK;
          state_n  = S_RESP;
        end else if (wdog == WD_LAST) begin
          quot_n   = '0;
          status_n = ST_TIMEOUT;
          state_n  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          ptr_n   = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gid    <= '0;
      opa    <= '0;
      opb    <= '0;
      quot   <= '0;
      status <= ST_OK;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gid    <= gid_n;
      opa    <= opa_n;
      opb    <= opb_n;
      quot   <= quot_n;
      status <= status_n;
      wdog   <= wdog_n;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a latency-configurable divider model and a response scoreboard.
module tb_div_arbiter;

  localparam int NREQ  = 4;
  localparam int N     = 32;
  localparam int DIGIT = 32;
  localparam int TMO   = 127;
  localparam int IDW   = 2;
  localparam int QW    = N + DIGIT;

  typedef struct {
    logic [IDW-1:0] id;
    logic [QW-1:0]  quot;
    logic [1:0]     status;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][N-1:0]  req_dividend;
  logic [NREQ-1:0][N-1:0]  req_divisor;
  logic                    div_start;
  logic [N-1:0]            div_dividend;
  logic [N-1:0]            div_divisor;
  logic                    model_done;
  logic                    stray_done;
  logic [QW-1:0]           model_quot;
  logic [QW-1:0]           stray_quot;
  logic                    div_done;
  logic [QW-1:0]           div_quot;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [QW-1:0]           rsp_quot;
  logic [1:0]              rsp_status;

  assign div_done = model_done | stray_done;
  assign div_quot = stray_done ? stray_quot : model_quot;

  div_arbiter #(.NREQ(NREQ), .N(N), .DIGIT(DIGIT), .TIMEOUT(TMO), .IDW(IDW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_dividend_i (req_dividend),
    .req_divisor_i  (req_divisor),
    .div_start_o    (div_start),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_done_i     (div_done),
    .div_quot_i     (div_quot),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_quot_o     (rsp_quot),
    .rsp_status_o   (rsp_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cnt = 0;
  always @(negedge clk) if (div_start) start_cnt = start_cnt + 1;

  // Divider model: done pulses L cycles after the cycle in which start is seen.
  int          div_lat = 4;
  bit          div_en  = 1'b1;
  int          mcnt;
  bit          mbusy;
  logic [QW-1:0] mres;
  initial begin
    model_done = 1'b0;
    model_quot = '0;
    mbusy      = 1'b0;
    mcnt       = 0;
    mres       = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (rst) begin
        mbusy = 1'b0;
      end else if (mbusy) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          mbusy      = 1'b0;
          model_done = 1'b1;
          model_quot = mres;
        end
      end else if (div_start && div_en) begin
        mbusy = 1'b1;
        mcnt  = div_lat;
        mres  = {div_dividend, {DIGIT{1'b0}}} / {{DIGIT{1'b0}}, div_divisor};
      end
    end
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.id = IDW'(id);
    if (b == '0) begin
      e.quot   = '1;
      e.status = 2'd1;
    end else begin
      e.quot   = {a, {DIGIT{1'b0}}} / {{DIGIT{1'b0}}, b};
      e.status = 2'd0;
    end
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: response with empty scoreboard, observed id=%0d", tag, rsp_id);
    end else begin
      e = sb.pop_front();
      check({tag, "_id"},     QW'(rsp_id),     QW'(e.id));
      check({tag, "_quot"},   rsp_quot,        e.quot);
      check({tag, "_status"}, QW'(rsp_status), QW'(e.status));
    end
  endtask

  // Raise one request at a negedge, check the same-cycle ready, push the expectation.
  task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit tmo, output int t);
    exp_t e;
    @(negedge clk);
    req_dividend[id] = a;
    req_divisor[id]  = b;
    req_valid[id]    = 1'b1;
    #1;
    check("accept_ready", QW'(req_ready), QW'(1 << id));
    t = cyc;
    e = mk_exp(id, a, b);
    if (tmo) begin
      e.quot   = '0;
      e.status = 2'd2;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $error("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, observed cycle=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    int at;
    int grants;
    int gidx;
    int s0;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;
    stray_done   = 1'b0;
    stray_quot   = '0;

    repeat (3) @(negedge clk);
    check("rst_req_ready",  QW'(req_ready),  '0);
    check("rst_div_start",  QW'(div_start),  '0);
    check("rst_rsp_valid",  QW'(rsp_valid),  '0);
    check("rst_rsp_quot",   rsp_quot,        '0);
    check("rst_rsp_status", QW'(rsp_status), '0);
    check("rst_ptr",        QW'(dut.ptr),    '0);
    rst = 1'b0;

    // Round-robin with all requesters continuously valid.
    div_lat = 3;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i] = N'(1000 + 37 * i);
      req_divisor[i]  = N'(3 + i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    grants    = 0;
    for (int i = 0; i < 300 && (grants < 5 || sb.size() > 0); i++) begin
      #1;
      if (rsp_valid) pop_check("rr_rsp");
      if (req_ready != '0) begin
        gidx = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gidx = k;
        check("rr_onehot", QW'($countones(req_ready)), QW'(1));
        check("rr_order",  QW'(gidx), QW'(order[grants]));
        sb.push_back(mk_exp(gidx, req_dividend[gidx], req_divisor[gidx]));
        grants++;
      end
      @(negedge clk);
      if (grants == 5) req_valid = '0;
    end
    check("rr_grants",  QW'(grants),    QW'(5));
    check("rr_drained", QW'(sb.size()), '0);
    rsp_ready = 1'b0;

    // Single request, OK path, L=64.
    div_lat = 64;
    send(2, 32'd100, 32'd7, 1'b0, t);
    @(negedge clk);
    check("ok_start",    QW'(div_start),    QW'(1));
    check("ok_dividend", QW'(div_dividend), QW'(100));
    wait_rsp(100, at);
    check("ok_latency",  QW'(at),          QW'(t + 66));
    check("ok_divisor_held", QW'(div_divisor), QW'(7));
    pop_check("ok");
    handshake();

    // Divide by zero never reaches the divider.
    s0 = start_cnt;
    send(1, 32'd5, 32'd0, 1'b0, t);
    wait_rsp(5, at);
    check("dbz_latency", QW'(at), QW'(t + 1));
    pop_check("dbz");
    check("dbz_no_start", QW'(start_cnt), QW'(s0));
    handshake();

    // Watchdog expiry, then a stray done in IDLE.
    div_en = 1'b0;
    send(3, 32'd9, 32'd2, 1'b1, t);
    wait_rsp(200, at);
    check("tmo_latency", QW'(at), QW'(t + 2 + TMO));
    pop_check("tmo");
    handshake();
    stray_quot = 64'h1234_5678_9abc_def0;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_rsp_valid", QW'(rsp_valid),  '0);
    check("stray_rsp_quot",  rsp_quot,        '0);
    check("stray_status",    QW'(rsp_status), QW'(2));
    check("stray_start",     QW'(div_start),  '0);
    div_en = 1'b1;

    // Backpressure: response held stable, no accept while in RESP.
    div_lat = 5;
    send(0, 32'd50, 32'd3, 1'b0, t);
    wait_rsp(20, at);
    check("bp_latency", QW'(at), QW'(t + 7));
    req_dividend[1] = 32'd77;
    req_divisor[1]  = 32'd11;
    req_valid[1]    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid",  QW'(rsp_valid),  QW'(1));
      check("bp_id",     QW'(rsp_id),     '0);
      check("bp_quot",   rsp_quot,        sb[0].quot);
      check("bp_status", QW'(rsp_status), '0);
      check("bp_no_accept", QW'(req_ready), '0);
      @(negedge clk);
    end
    pop_check("bp");
    handshake();
    check("bp_next_accept", QW'(req_ready), QW'(4'b0010));

    // Reset in the middle of WAIT.
    div_lat = 20;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_req_ready", QW'(req_ready),    '0);
    check("mrst_div_start", QW'(div_start),    '0);
    check("mrst_rsp_valid", QW'(rsp_valid),    '0);
    check("mrst_rsp_id",    QW'(rsp_id),       '0);
    check("mrst_rsp_quot",  rsp_quot,          '0);
    check("mrst_status",    QW'(rsp_status),   '0);
    check("mrst_dividend",  QW'(div_dividend), '0);
    check("mrst_divisor",   QW'(div_divisor),  '0);
    check("mrst_ptr",       QW'(dut.ptr),      '0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mrst_quiet", QW'(rsp_valid), '0);
    check("final_sb_empty", QW'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencing and arbitration front-end for one shared iterative fixed-point divider (quotient = dividend / divisor with `DIGIT` fraction bits, one quotient bit per cycle). The arbiter accepts divide requests from `NREQ` independent requesters and grants them round-robin. It issues exactly one operation at a time to the divider, waits for completion under a watchdog, and returns the quotient to the granted requester with a status code. Divide-by-zero is trapped locally and never reaches the divider.

## Interface
- `NREQ`, 4: number of requesters; must be ≥ 2.
- `N`, 32: dividend and divisor width.
- `DIGIT`, 32: fraction bits; quotient width is `N+DIGIT`.
- `TIMEOUT`, 127: maximum WAIT cycles before the watchdog aborts.
- `IDW`, `$clog2(NREQ)`: requester ID width.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in `NREQ`: per-requester request valid.
- `req_ready_o` out `NREQ`: one-hot accept strobe, 1 cycle.
- `req_dividend_i` in `NREQ`×`N`: per-requester dividend.
- `req_divisor_i` in `NREQ`×`N`: per-requester divisor.
- `div_start_o` out 1: 1-cycle start pulse to the divider.
- `div_dividend_o` out `N`: latched dividend; stable from start until done.
- `div_divisor_o` out `N`: latched divisor; stable from start until done.
- `div_done_i` in 1: divider completion pulse.
- `div_quot_i` in `N+DIGIT`: divider result; valid with `div_done_i`.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response accepted.
- `rsp_id_o` out `IDW`: index of the requester being answered.
- `rsp_quot_o` out `N+DIGIT`: quotient.
- `rsp_status_o` out 2: 0 = OK, 1 = DBZ, 2 = TIMEOUT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Reset values: all outputs 0, rotate pointer `ptr` = 0, watchdog count 0.
- IDLE:
  - If any `req_valid_i` is set, grant the first set bit at or after `ptr`, wrapping modulo `NREQ`.
  - Assert `req_ready_o[g]` in the same cycle (combinational on valid while in IDLE).
  - Latch the granted operands and `g`.
  - Divisor == 0: go to RESP with status DBZ and quotient all ones.
  - Otherwise go to ISSUE.
- ISSUE: assert `div_start_o` for one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - On `div_done_i`: capture `div_quot_i`, status OK, go to RESP.
  - If the watchdog reaches `TIMEOUT` without done: quotient 0, status TIMEOUT, go to RESP.
  - If done and the timeout occur in the same cycle, done wins (status OK).
- RESP:
  - Hold `rsp_valid_o` and all `rsp_*` stable until `rsp_ready_i`.
  - On handshake: set `ptr` = `(g+1) mod NREQ` and go to IDLE.
- `div_done_i` outside WAIT is ignored and does not affect state or outputs.
- `req_ready_o` is 0 in every state except IDLE. A requester keeps its request and operands stable until it is readied.
- Requests are never dropped. A requester that is not granted stays pending.
- Starvation bound: a continuously asserted request is granted within `NREQ` operations.
- `rst_i` in any state aborts immediately to IDLE with reset values. The divider must also be reset by the same `rst_i`; a late `div_done_i` is ignored.

## Timing
- Accept at cycle T (IDLE). `div_start_o` at T+1. With divider latency L (done at T+1+L), `rsp_valid_o` rises at T+2+L.
- DBZ path: `rsp_valid_o` rises at T+1.
- Timeout path: `rsp_valid_o` rises at T+2+`TIMEOUT`.
- After the response handshake at cycle R, the next accept can occur at R+1. Peak issue rate is one operation per L+3 cycles.
- Operands on `div_*_o` remain constant from ISSUE through WAIT exit.

## Structure
- Package `div_arb_pkg`:
  - `state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `status_t` enum (OK=0, DBZ=1, TIMEOUT=2).
  - Default width constants.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `ptr`; outputs are a one-hot grant, the encoded index and an any-request flag.
- FSM, operand/result registers and watchdog live in `div_arbiter`. Expected size is about 200 lines of RTL.

## Test plan
- Single request, OK path: requester 2 sends 100/7, divider model with L=64. Expect `rsp_id_o`=2, quotient = 100·2^32/7 truncated, status 0, `rsp_valid_o` at T+66.
- Round-robin fairness: all 4 requesters valid continuously. Grants must follow 0,1,2,3,0 and no requester waits more than 4 operations.
- Divide-by-zero: requester 1 sends 5/0. Expect `div_start_o` never asserted, response at T+1 with quotient all ones and status 1.
- Timeout and stray done: divider never signals done. Expect status 2 and quotient 0 at T+2+127. A `div_done_i` injected afterwards in IDLE must be ignored.
- Backpressure and mid-operation reset: hold `rsp_ready_i`=0 for 10 cycles and check the response stays stable, with no new accept. Assert `rst_i` during WAIT and check all outputs are 0 and `ptr`=0 the next cycle.
